// File: rtl/pc_stack_if.sv
// Command and status bundle for pc_stack: the sequencer (master) drives commands
// and the jump target; the stack (slave) returns the program counter and stack status.
interface pc_stack_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic              incPC;
  logic              loadPC;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] newaddr;
  logic [ADDR_W-1:0] addr;
  logic [DW-1:0]     depth;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output incPC, loadPC, call, ret, newaddr,
    input  addr, depth, full, empty, overflow, underflow
  );

  modport slave (
    input  incPC, loadPC, call, ret, newaddr,
    output addr, depth, full, empty, overflow, underflow
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with a DEPTH-entry return-address stack.
// Define PC_STACK_WRAP_EN to make a call on a full stack overwrite the oldest entry.
module pc_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  pc_stack_if.slave   bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_CNT = DW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_inc;
  logic [DW-1:0]     depth_q;
  logic [PW-1:0]     top_ptr;   // next free slot; with a full stack also the oldest entry
  logic [PW-1:0]     next_ptr;
  logic [PW-1:0]     prev_ptr;
  logic              full_q;
  logic              empty_q;
  logic              ovf_q;
  logic              unf_q;
  logic              push_en;
  logic              wrap_ok;

`ifdef PC_STACK_WRAP_EN
  assign wrap_ok = 1'b1;
`else
  assign wrap_ok = 1'b0;
`endif

  assign addr_inc = addr_q + ADDR_W'(1);
  assign full_q   = (depth_q == DEPTH_CNT);
  assign empty_q  = (depth_q == '0);
  assign next_ptr = (top_ptr == LAST_PTR) ? '0 : top_ptr + PW'(1);
  assign prev_ptr = (top_ptr == '0) ? LAST_PTR : top_ptr - PW'(1);

  // ret outranks call, so a simultaneous call never writes the stack.
  assign push_en = !reset && !bus.ret && bus.call && (!full_q || wrap_ok);

  // NOTE: stack storage has no reset; entries above depth are never read, so
  // leaving them unreset keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (push_en) mem[top_ptr] <= addr_inc;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      depth_q <= '0;
      top_ptr <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.ret) begin
      if (empty_q) begin
        unf_q <= 1'b1;
      end else begin
        addr_q  <= mem[prev_ptr];
        top_ptr <= prev_ptr;
        depth_q <= depth_q - DW'(1);
      end
    end else if (bus.call) begin
      if (full_q) begin
        ovf_q <= 1'b1;
        if (wrap_ok) begin
          addr_q  <= bus.newaddr;
          top_ptr <= next_ptr;
        end
      end else begin
        addr_q  <= bus.newaddr;
        top_ptr <= next_ptr;
        depth_q <= depth_q + DW'(1);
      end
    end else if (bus.loadPC) begin
      addr_q <= bus.newaddr;
    end else if (bus.incPC) begin
      addr_q <= addr_inc;
    end
  end

  assign bus.addr      = addr_q;
  assign bus.depth     = depth_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios plus random commands,
// compared every cycle against a queue-based reference model.
module tb_pc_stack;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam int DW     = $clog2(DEPTH + 1);
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_stack_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  pc_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: return addresses in a queue, newest at the back.
  int m_addr = 0;
  int m_stack[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit rs, input bit inc, input bit ld, input bit cl,
                       input bit rt, input int na);
    int ra;
    if (rs) begin
      m_addr = 0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (rt) begin
      if (m_stack.size() == 0) m_unf = 1;
      else m_addr = m_stack.pop_back();
    end else if (cl) begin
      ra = (m_addr + 1) & MASK;
      if (m_stack.size() == DEPTH) begin
        m_ovf = 1;
`ifdef PC_STACK_WRAP_EN
        void'(m_stack.pop_front());
        m_stack.push_back(ra);
        m_addr = na;
`endif
      end else begin
        m_stack.push_back(ra);
        m_addr = na;
      end
    end else if (ld) begin
      m_addr = na;
    end else if (inc) begin
      m_addr = (m_addr + 1) & MASK;
    end
  endtask

  task automatic compare_all();
    int d;
    d = m_stack.size();
    check("addr",      int'(bus.addr),      m_addr);
    check("depth",     int'(bus.depth),     d);
    check("full",      int'(bus.full),      int'(d == DEPTH));
    check("empty",     int'(bus.empty),     int'(d == 0));
    check("overflow",  int'(bus.overflow),  int'(m_ovf));
    check("underflow", int'(bus.underflow), int'(m_unf));
  endtask

  // One cycle: drive at negedge, sample #1 after the rising edge.
  task automatic step(input bit rs, input bit inc, input bit ld, input bit cl,
                      input bit rt, input int na);
    @(negedge clk);
    reset       = rs;
    bus.incPC   = inc;
    bus.loadPC  = ld;
    bus.call    = cl;
    bus.ret     = rt;
    bus.newaddr = ADDR_W'(na);
    @(posedge clk);
    #1;
    model(rs, inc, ld, cl, rt, na);
    compare_all();
  endtask

  task automatic do_reset();  step(1, 0, 0, 0, 0, 0);  endtask
  task automatic do_inc();    step(0, 1, 0, 0, 0, 0);  endtask
  task automatic do_load(input int a); step(0, 0, 1, 0, 0, a); endtask
  task automatic do_call(input int a); step(0, 0, 0, 1, 0, a); endtask
  task automatic do_ret();    step(0, 0, 0, 0, 1, 0);  endtask

  task automatic fill_stack();
    do_reset();
    do_load('h001);
    do_call('h101);
    do_call('h201);
    do_call('h301);
    do_call('h401);
    check("fill_full", int'(bus.full), 1);
  endtask

  initial begin
    reset       = 1'b1;
    bus.incPC   = 1'b0;
    bus.loadPC  = 1'b0;
    bus.call    = 1'b0;
    bus.ret     = 1'b0;
    bus.newaddr = '0;

    // Reset dominates a simultaneous call.
    step(1, 1, 1, 1, 0, 'h123);
    check("rst_addr",  int'(bus.addr),  0);
    check("rst_empty", int'(bus.empty), 1);

    // Increment wrap.
    do_load('hFFE);
    do_inc();
    check("inc_fff", int'(bus.addr), 'hFFF);
    do_inc();
    check("inc_wrap", int'(bus.addr), 'h000);

    // Single call/ret.
    do_load('h010);
    do_call('h200);
    check("call_addr",  int'(bus.addr),  'h200);
    check("call_depth", int'(bus.depth), 1);
    do_ret();
    check("ret_addr",  int'(bus.addr),  'h011);
    check("ret_depth", int'(bus.depth), 0);
    check("ret_empty", int'(bus.empty), 1);

    // Nesting to full, unwind in LIFO order.
    fill_stack();
    do_ret(); check("nest_ret0", int'(bus.addr), 'h302);
    do_ret(); check("nest_ret1", int'(bus.addr), 'h202);
    do_ret(); check("nest_ret2", int'(bus.addr), 'h102);
    do_ret(); check("nest_ret3", int'(bus.addr), 'h002);

    // Call on a full stack.
    fill_stack();
    do_call('h555);
    check("ovf_flag",  int'(bus.overflow), 1);
    check("ovf_depth", int'(bus.depth),    DEPTH);
`ifdef PC_STACK_WRAP_EN
    check("ovf_addr", int'(bus.addr), 'h555);
    do_ret(); check("ovf_ret0", int'(bus.addr), 'h402);
    do_ret(); check("ovf_ret1", int'(bus.addr), 'h302);
    do_ret(); check("ovf_ret2", int'(bus.addr), 'h202);
    do_ret(); check("ovf_ret3", int'(bus.addr), 'h102);
`else
    check("ovf_addr", int'(bus.addr), 'h401);
    do_ret(); check("ovf_ret0", int'(bus.addr), 'h302);
`endif
    check("ovf_sticky", int'(bus.overflow), 1);

    // Underflow and ret-over-call priority.
    do_reset();
    do_load('h0AB);
    do_ret();
    check("unf_addr", int'(bus.addr),      'h0AB);
    check("unf_flag", int'(bus.underflow), 1);
    do_load('h050);
    do_call('h123);
    step(0, 1, 1, 1, 1, 'h777);
    check("prio_addr",  int'(bus.addr),     'h051);
    check("prio_depth", int'(bus.depth),    0);
    check("prio_ovf",   int'(bus.overflow), 0);
    check("unf_sticky", int'(bus.underflow), 1);

    // Reset mid-operation: depth 3 with overflow set.
    fill_stack();
    do_call('h666);
    do_ret();
    check("mid_depth", int'(bus.depth),    3);
    check("mid_ovf",   int'(bus.overflow), 1);
    step(1, 0, 0, 1, 0, 'h321);
    check("mid_rst_addr",  int'(bus.addr),     0);
    check("mid_rst_depth", int'(bus.depth),    0);
    check("mid_rst_ovf",   int'(bus.overflow), 0);
    check("mid_rst_unf",   int'(bus.underflow), 0);

    // Random commands; call/ret biased so the stack sweeps its whole range.
    for (int i = 0; i < 3000; i++) begin
      bit rs, inc, ld, cl, rt;
      rs  = ($urandom_range(0, 99) == 0);
      inc = $urandom_range(0, 1) == 1;
      ld  = ($urandom_range(0, 3) == 0);
      cl  = ($urandom_range(0, 2) == 0);
      rt  = ($urandom_range(0, 2) == 0);
      step(rs, inc, ld, cl, rt, int'($urandom_range(0, MASK)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
